i2c_slave_rx: RTL and testbench

- I2C slave receiver that sits downstream of the I2C master block.
- Samples the master's SCL/SDA lines on the system clock and detects START and STOP conditions.
- Matches a 7-bit slave address, ACKs the address and each received byte, and presents each received byte on a parallel output with a one-cycle valid strobe.
- Used as the on-chip loop-back target for master bring-up and as the receive front end of slave peripherals.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_line_sync.sv | 32 +++
 rtl/i2c_slave_rx.sv | 142 ++++++++++++++
 tb/tb_i2c_slave_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receiver.
// State encoding, R/W bit position and ACK drive levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam int   RW_BIT  = 0;
    localparam logic ACK_OE  = 1'b1;
    localparam logic NACK_OE = 1'b0;

    // Only writes to our own address are accepted.
    function automatic logic addr_match(input logic [7:0] b,
                                        input logic [6:0] a);
        return (b[7:1] == a) && (b[RW_BIT] == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchroniser for one bus line with edge detection.
// Resets to the idle-high bus level so reset never fakes an edge.
module i2c_line_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C write-only slave receiver: START/STOP detect, address match,
// byte ACK and parallel byte output with a one-cycle valid strobe.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h19,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SCL,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       ADDR_HIT,
    output logic       BUSY
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (SCL),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (SDA_IN),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start = sda_fall & scl_lvl;
    assign stop  = sda_rise & scl_lvl;

    i2c_state_e state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic [7:0] shift, shift_nx;
    logic       full, full_nx;
    logic       hit_nx, busy_nx, dv_nx;
    logic [7:0] dout_nx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            shift      <= 8'h00;
            full       <= 1'b0;
            ADDR_HIT   <= 1'b0;
            BUSY       <= 1'b0;
            DATA_OUT   <= 8'h00;
            DATA_VALID <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            shift      <= shift_nx;
            full       <= full_nx;
            ADDR_HIT   <= hit_nx;
            BUSY       <= busy_nx;
            DATA_OUT   <= dout_nx;
            DATA_VALID <= dv_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift_nx = shift;
        full_nx  = full;
        hit_nx   = ADDR_HIT;
        busy_nx  = BUSY;
        dout_nx  = DATA_OUT;
        dv_nx    = 1'b0;
        if (start) begin
            state_nx = ST_ADDR;
            cnt_nx   = 3'd0;
            shift_nx = 8'h00;
            full_nx  = 1'b0;
            hit_nx   = 1'b0;
            busy_nx  = 1'b1;
        end else if (stop) begin
            state_nx = ST_IDLE;
            cnt_nx   = 3'd0;
            shift_nx = 8'h00;
            full_nx  = 1'b0;
            hit_nx   = 1'b0;
            busy_nx  = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR, ST_DATA: begin
                    // cnt parks at 7 once the byte is full; ACK entry wraps it
                    if (scl_rise && !full) begin
                        shift_nx = {shift[6:0], sda_lvl};
                        if (cnt == 3'd7) begin
                            full_nx = 1'b1;
                            if (state == ST_DATA) begin
                                dout_nx = shift_nx;
                                dv_nx   = 1'b1;
                            end
                        end else begin
                            cnt_nx = cnt + 3'd1;
                        end
                    end else if (scl_fall && full) begin
                        full_nx = 1'b0;
                        cnt_nx  = 3'd0;
                        if (state == ST_DATA) begin
                            state_nx = ST_DATA_ACK;
                        end else if (addr_match(shift, SLAVE_ADDR)) begin
                            state_nx = ST_ADDR_ACK;
                            hit_nx   = 1'b1;
                        end else begin
                            state_nx = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        state_nx = ST_DATA;
                        shift_nx = 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        SDA_OE = NACK_OE;
        if (state == ST_ADDR_ACK || state == ST_DATA_ACK)
            SDA_OE = ACK_OE;
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: table-driven writes plus
// hand sequences, received bytes checked against a scoreboard queue.
module tb_i2c_slave_rx;

    localparam time Q = 100ns;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       SDA_OE;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       ADDR_HIT;
    logic       BUSY;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    assign sda_line = m_sda & ~SDA_OE;

    always #5ns CLK = ~CLK;

    i2c_slave_rx dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SCL        (scl),
        .SDA_IN     (sda_line),
        .SDA_OE     (SDA_OE),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .ADDR_HIT   (ADDR_HIT),
        .BUSY       (BUSY)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && DATA_VALID) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dv_unexpected: got %0h expected none",
                         DATA_OUT);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (DATA_OUT !== e) begin
                    errors++;
                    $display("FAIL dv_data: got %0h expected %0h",
                             DATA_OUT, e);
                end
            end
        end
    end

    task automatic start_c();
        m_sda = 1'b1; scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic rstart_c();
        m_sda = 1'b1; #Q;
        scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic stop_c();
        m_sda = 1'b0; #Q;
        scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack,
                             input string name);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #Q;
        scl = 1'b1; #Q;
        chk(name, SDA_OE, ack);
        #Q;
        scl = 1'b0; #Q;
    endtask

    typedef struct {
        logic [7:0] addr;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h32, 1, 8'hF0, 8'h00, 1'b1, 8'hF0};
        vecs[1] = '{8'h34, 1, 8'hAA, 8'h00, 1'b0, 8'hF0};
        vecs[2] = '{8'h33, 1, 8'h55, 8'h00, 1'b0, 8'hF0};
        vecs[3] = '{8'h32, 2, 8'hA5, 8'h3C, 1'b1, 8'h3C};
        vecs[4] = '{8'h30, 1, 8'h01, 8'h00, 1'b0, 8'h3C};

        #37ns;
        chk("rst_sda_oe", SDA_OE, 0);
        chk("rst_data_out", DATA_OUT, 8'h00);
        chk("rst_data_valid", DATA_VALID, 0);
        chk("rst_addr_hit", ADDR_HIT, 0);
        chk("rst_busy", BUSY, 0);
        RST_N = 1'b1;
        #Q;

        for (int v = 0; v < 5; v++) begin
            start_c();
            chk($sformatf("v%0d_busy_start", v), BUSY, 1);
            send_byte(vecs[v].addr, vecs[v].ack,
                      $sformatf("v%0d_addr_ack", v));
            chk($sformatf("v%0d_addr_hit", v), ADDR_HIT, vecs[v].ack);
            if (vecs[v].ack) exp_q.push_back(vecs[v].d0);
            send_byte(vecs[v].d0, vecs[v].ack, $sformatf("v%0d_d0_ack", v));
            if (vecs[v].n > 1) begin
                if (vecs[v].ack) exp_q.push_back(vecs[v].d1);
                send_byte(vecs[v].d1, vecs[v].ack,
                          $sformatf("v%0d_d1_ack", v));
            end
            chk($sformatf("v%0d_hit_hold", v), ADDR_HIT, vecs[v].ack);
            stop_c();
            chk($sformatf("v%0d_busy_stop", v), BUSY, 0);
            chk($sformatf("v%0d_hit_stop", v), ADDR_HIT, 0);
            chk($sformatf("v%0d_dout", v), DATA_OUT, vecs[v].dout);
            chk($sformatf("v%0d_q_empty", v), exp_q.size(), 0);
            #Q;
        end

        // multi-byte with repeated START
        start_c();
        send_byte(8'h32, 1'b1, "rs_addr1_ack");
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1, "rs_d11_ack");
        exp_q.push_back(8'h22);
        send_byte(8'h22, 1'b1, "rs_d22_ack");
        rstart_c();
        chk("rs_hit_cleared", ADDR_HIT, 0);
        chk("rs_busy_kept", BUSY, 1);
        send_byte(8'h32, 1'b1, "rs_addr2_ack");
        exp_q.push_back(8'h33);
        send_byte(8'h33, 1'b1, "rs_d33_ack");
        stop_c();
        chk("rs_dout", DATA_OUT, 8'h33);
        chk("rs_q_empty", exp_q.size(), 0);
        #Q;

        // abort after 4 data bits
        start_c();
        send_byte(8'h32, 1'b1, "ab_addr_ack");
        for (int i = 7; i >= 4; i--) send_bit(8'hC5 >> i);
        stop_c();
        chk("ab_sda_oe", SDA_OE, 0);
        chk("ab_busy", BUSY, 0);
        chk("ab_hit", ADDR_HIT, 0);
        chk("ab_dout_hold", DATA_OUT, 8'h33);
        #Q;
        start_c();
        send_byte(8'h32, 1'b1, "ab2_addr_ack");
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, "ab2_d_ack");
        stop_c();
        chk("ab2_dout", DATA_OUT, 8'h5A);
        chk("ab2_q_empty", exp_q.size(), 0);
        #Q;

        // reset while the address ACK is driven
        start_c();
        for (int i = 7; i >= 0; i--) send_bit(8'h32 >> i);
        m_sda = 1'b1; #Q;
        scl = 1'b1; #Q;
        chk("rm_ack_on", SDA_OE, 1);
        RST_N = 1'b0;
        #1ns;
        chk("rm_sda_oe_async", SDA_OE, 0);
        chk("rm_dout", DATA_OUT, 8'h00);
        chk("rm_hit", ADDR_HIT, 0);
        chk("rm_busy", BUSY, 0);
        chk("rm_dv", DATA_VALID, 0);
        #(Q-1ns);
        RST_N = 1'b1;
        scl = 1'b0; #Q;
        stop_c();
        chk("rm_idle_oe", SDA_OE, 0);
        #Q;
        start_c();
        send_byte(8'h32, 1'b1, "rm2_addr_ack");
        exp_q.push_back(8'h77);
        send_byte(8'h77, 1'b1, "rm2_d_ack");
        stop_c();
        chk("rm2_dout", DATA_OUT, 8'h77);
        chk("rm2_q_empty", exp_q.size(), 0);
        #Q;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
